limp_executor: RTL

- Actuator side of the cleaning-state code produced by the cleaning-state register (2-bit code: 00 NADA, 01 ADB, 10 LIMP).
- Turns the code into timed valve commands: fill, flush, drain.
- Reports completion and fault conditions back to the control FSM.
- Sits between the state register and the valve drivers. All outputs are Moore-decoded from a registered state.

---
 rtl/limp_executor.sv | 134 +++++++++++++
 1 files changed

// File: rtl/limp_executor.sv
// Cleaning-state actuator sequencer: turns the NADA/ADB/LIMP code into timed fill/flush/drain valve commands.
// Optional build macro LIMP_EXEC_CYCLE_COUNT_EN adds a saturating completed-cycle counter output.
//
// state | meaning
// IDLE  | valves closed, waiting for a cleaning request
// FILL  | supply valve open until tank no longer low (or timeout)
// FLUSH | cleaning valve open for FLUSH_CYCLES
// DRAIN | cleaning valve open for DRAIN_CYCLES
// DONE  | one-cycle completion pulse
// HOLD  | request served, waiting for cmd to return to NADA
// FAULT | sticky fault, valves closed
module limp_executor #(
  parameter int FILL_MAX     = 16,
  parameter int FLUSH_CYCLES = 8,
  parameter int DRAIN_CYCLES = 4,
  parameter int CNT_W        = 8
) (
  input  logic       clock_i,
  input  logic       reset_ni,
  input  logic [1:0] cmd_i,
  input  logic       low_i,
  input  logic       critico_i,
  input  logic       rega_i,
  output logic       adb_o,
  output logic       ve_o,
  output logic       busy_o,
  output logic       done_o,
  output logic       fault_o,
`ifdef LIMP_EXEC_CYCLE_COUNT_EN
  output logic [7:0] cycles_done_o,
`endif
  output logic [2:0] phase_o
);

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    FILL  = 3'd1,
    FLUSH = 3'd2,
    DRAIN = 3'd3,
    DONE  = 3'd4,
    HOLD  = 3'd5,
    FAULT = 3'd6
  } state_t;

  localparam logic [1:0] CMD_NADA = 2'b00;
  localparam logic [1:0] CMD_ADB  = 2'b01;
  localparam logic [1:0] CMD_LIMP = 2'b10;
  localparam logic [1:0] CMD_BAD  = 2'b11;

  localparam logic [CNT_W-1:0] FILL_LAST  = CNT_W'(FILL_MAX - 1);
  localparam logic [CNT_W-1:0] FLUSH_LAST = CNT_W'(FLUSH_CYCLES - 1);
  localparam logic [CNT_W-1:0] DRAIN_LAST = CNT_W'(DRAIN_CYCLES - 1);

  state_t           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             active;

  assign active = (state_q == FILL) || (state_q == FLUSH) || (state_q == DRAIN);

  always_comb begin
    state_d = state_q;
    if (critico_i && state_q != FAULT) begin
      state_d = FAULT;
    end else if (active && cmd_i == CMD_BAD) begin
      state_d = FAULT;
    end else if (active && cmd_i == CMD_NADA) begin
      state_d = IDLE;
    end else begin
      case (state_q)
        IDLE: begin
          if (!rega_i) begin
            if (cmd_i == CMD_ADB)       state_d = FILL;
            else if (cmd_i == CMD_LIMP) state_d = low_i ? FILL : FLUSH;
          end
        end
        // Level clearing takes precedence over the timeout in the same cycle.
        FILL: begin
          if (!low_i && cmd_i == CMD_LIMP)     state_d = FLUSH;
          else if (!low_i && cmd_i == CMD_ADB) state_d = DONE;
          else if (cnt_q == FILL_LAST)         state_d = FAULT;
        end
        FLUSH: if (cnt_q == FLUSH_LAST) state_d = DRAIN;
        DRAIN: if (cnt_q == DRAIN_LAST) state_d = DONE;
        DONE:  state_d = HOLD;
        HOLD:  if (cmd_i == CMD_NADA) state_d = IDLE;
        FAULT: if (cmd_i == CMD_NADA && !critico_i) state_d = IDLE;
        default: state_d = IDLE;
      endcase
    end
  end

  always_comb begin
    cnt_d = cnt_q;
    if (state_d != state_q) cnt_d = '0;
    else if (active)        cnt_d = cnt_q + 1'b1;
  end

  always_ff @(posedge clock_i or negedge reset_ni) begin
    if (!reset_ni) begin
      state_q <= IDLE;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  assign adb_o   = (state_q == FILL);
  assign ve_o    = (state_q == FLUSH) || (state_q == DRAIN);
  assign busy_o  = active;
  assign done_o  = (state_q == DONE);
  assign fault_o = (state_q == FAULT);
  assign phase_o = state_q;

`ifdef LIMP_EXEC_CYCLE_COUNT_EN
  logic [7:0] cycles_q, cycles_d;

  always_comb begin
    cycles_d = cycles_q;
    if (state_q == FAULT && state_d == IDLE)
      cycles_d = '0;
    else if (state_d == DONE && state_q != DONE && cycles_q != 8'hFF)
      cycles_d = cycles_q + 8'd1;
  end

  always_ff @(posedge clock_i or negedge reset_ni) begin
    if (!reset_ni) cycles_q <= '0;
    else           cycles_q <= cycles_d;
  end

  assign cycles_done_o = cycles_q;
`endif

endmodule
